// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS sample source for an 8-bit offset-binary parallel DAC.
// Ports: clk/rst_n, en, cfg_valid/cfg_ready/cfg_ftw/cfg_wave/cfg_amp, dac_data, sync.
module dds_wave_gen #(
    parameter int                 PHASE_W = 32,
    parameter logic [PHASE_W-1:0] FTW_RST = 32'h0147_AE14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_amp,
    output logic [7:0]         dac_data,
    output logic               sync
);

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

    // Quarter-wave sine magnitudes, sampled at bin centres.
    localparam logic [6:0] SINE_Q [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    // Stage 1: phase accumulator and active/shadow configuration
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    wave_e              wave_q, wave_d;
    logic [7:0]         amp_q, amp_d;
    logic               full_q, full_d;
    logic [PHASE_W-1:0] sh_ftw_q, sh_ftw_d;
    wave_e              sh_wave_q, sh_wave_d;
    logic [7:0]         sh_amp_q, sh_amp_d;

    // Stage 2: raw sample with the amplitude it must be scaled by
    logic [7:0]         raw_q, raw_d;
    logic [7:0]         amp2_q, amp2_d;
    logic               sync2_q, sync2_d;

    // Stage 3: scaled output
    logic [7:0]         dac_q, dac_d;
    logic               sync_q, sync_d;

    logic [PHASE_W:0]   sum;
    logic               xfer;
    logic               apply;

    assign cfg_ready = ~full_q;
    assign dac_data  = dac_q;
    assign sync      = sync_q;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, ftw_q};
        acc_d  = en ? sum[PHASE_W-1:0] : '0;
        wrap_d = en & sum[PHASE_W];
    end

    // The shadow can only be loaded while empty, so load and apply
    // never happen on the same edge.
    assign xfer  = cfg_valid & ~full_q;
    assign apply = full_q & (wrap_d | ~en);

    always_comb begin
        ftw_d     = ftw_q;
        wave_d    = wave_q;
        amp_d     = amp_q;
        full_d    = full_q;
        sh_ftw_d  = sh_ftw_q;
        sh_wave_d = sh_wave_q;
        sh_amp_d  = sh_amp_q;
        if (apply) begin
            ftw_d  = sh_ftw_q;
            wave_d = sh_wave_q;
            amp_d  = sh_amp_q;
            full_d = 1'b0;
        end else if (xfer) begin
            sh_ftw_d  = cfg_ftw;
            sh_wave_d = wave_e'(cfg_wave);
            sh_amp_d  = cfg_amp;
            full_d    = 1'b1;
        end
    end

    logic [7:0] p8;
    logic [5:0] idx;
    logic [6:0] qmag;
    logic [7:0] sine_raw;
    logic [7:0] tri_raw;
    logic [7:0] wave_raw;

    always_comb begin
        p8 = acc_q[PHASE_W-1 -: 8];
        // 63 - x on six bits is the bitwise complement.
        idx      = p8[6] ? ~p8[5:0] : p8[5:0];
        qmag     = SINE_Q[idx];
        sine_raw = p8[7] ? (8'd127 - {1'b0, qmag})
                         : (8'd128 + {1'b0, qmag});
        tri_raw  = p8[7] ? ~{p8[6:0], 1'b0} : {p8[6:0], 1'b0};
        wave_raw = 8'h80;
        unique case (wave_q)
            WAVE_SINE: wave_raw = sine_raw;
            WAVE_TRI:  wave_raw = tri_raw;
            WAVE_SAW:  wave_raw = p8;
            WAVE_SQR:  wave_raw = p8[7] ? 8'h00 : 8'hFF;
        endcase
        // Midscale raw scales to midscale for any amplitude.
        raw_d   = en ? wave_raw : 8'h80;
        amp2_d  = amp_q;
        sync2_d = en & wrap_q;
    end

    logic signed [15:0] s_w;
    logic signed [15:0] a_w;
    logic signed [15:0] prod;
    logic               prod_lo_unused;

    always_comb begin
        s_w  = $signed({8'h00, raw_q}) - 16'sd128;
        a_w  = $signed({8'h00, amp2_q});
        // |s*amp| <= 32640, so 16 bits hold it exactly; bits [15:8]
        // are the floor of prod/256 in two's complement.
        prod   = s_w * a_w;
        dac_d  = prod[15:8] + 8'h80;
        sync_d = sync2_q;
    end

    assign prod_lo_unused = ^prod[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            wrap_q    <= 1'b0;
            ftw_q     <= FTW_RST;
            wave_q    <= WAVE_SINE;
            amp_q     <= 8'd255;
            full_q    <= 1'b0;
            sh_ftw_q  <= '0;
            sh_wave_q <= WAVE_SINE;
            sh_amp_q  <= 8'd0;
            raw_q     <= 8'h80;
            amp2_q    <= 8'd255;
            sync2_q   <= 1'b0;
            dac_q     <= 8'h80;
            sync_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wrap_q    <= wrap_d;
            ftw_q     <= ftw_d;
            wave_q    <= wave_d;
            amp_q     <= amp_d;
            full_q    <= full_d;
            sh_ftw_q  <= sh_ftw_d;
            sh_wave_q <= sh_wave_d;
            sh_amp_q  <= sh_amp_d;
            raw_q     <= raw_d;
            amp2_q    <= amp2_d;
            sync2_q   <= sync2_d;
            dac_q     <= dac_d;
            sync_q    <= sync_d;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed stimulus for dds_wave_gen with a behavioural
// sample model checked every cycle plus hand-computed literal expectations.
module tb_dds_wave_gen;

    localparam int          PW   = 32;
    localparam logic [31:0] FTW0 = 32'h0147_AE14;
    localparam logic [31:0] F24  = 32'h0100_0000;
    localparam logic [31:0] F25  = 32'h0200_0000;
    localparam logic [31:0] F23  = 32'h0080_0000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_ftw   = '0;
    logic [1:0]  cfg_wave  = '0;
    logic [7:0]  cfg_amp   = '0;
    logic [7:0]  dac_data;
    logic        sync;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    dds_wave_gen #(.PHASE_W(PW), .FTW_RST(FTW0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_wave  (cfg_wave),
        .cfg_amp   (cfg_amp),
        .dac_data  (dac_data),
        .sync      (sync)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int qtab[64];
    initial begin
        for (int i = 0; i < 64; i++)
            qtab[i] = $rtoi($floor(127.0 * $sin(3.14159265358979 *
                               (i + 0.5) / 128.0) + 0.5));
    end

    function automatic int wave_val(input int w, input int p8);
        int quad, m, ix;
        quad = p8 / 64;
        m    = p8 % 64;
        case (w)
            0: begin
                ix = (quad % 2 == 1) ? 63 - m : m;
                return (quad < 2) ? 128 + qtab[ix] : 127 - qtab[ix];
            end
            1: return (p8 < 128) ? 2 * p8 : 255 - 2 * (p8 - 128);
            2: return p8;
            default: return (p8 < 128) ? 255 : 0;
        endcase
    endfunction

    function automatic int scale(input int raw, input int amp);
        int prod, fl;
        prod = (raw - 128) * amp;
        fl   = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
        return 128 + fl;
    endfunction

    longint unsigned m_acc, m_ftw, s_ftw, m_sum;
    int  m_wave, m_amp, s_wave, s_amp;
    bit  m_full, m_fw, m_wrap;
    int  pend_dac, exp_dac, pv;
    bit  pend_sync, exp_sync, exp_ready, ps;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc     = 0;
            m_ftw     = FTW0;
            m_wave    = 0;
            m_amp     = 255;
            m_full    = 0;
            m_fw      = 0;
            pend_dac  = 128;
            exp_dac   = 128;
            pend_sync = 0;
            exp_sync  = 0;
            exp_ready = 1;
        end else begin
            pv = en ? scale(wave_val(m_wave, int'(m_acc >> (PW - 8))), m_amp)
                    : 128;
            ps = en && m_fw;
            exp_dac   = pend_dac;
            exp_sync  = pend_sync;
            pend_dac  = pv;
            pend_sync = ps;
            if (en) begin
                m_sum  = m_acc + m_ftw;
                m_wrap = (m_sum >= 64'h1_0000_0000);
                m_acc  = m_sum & 64'hFFFF_FFFF;
            end else begin
                m_acc  = 0;
                m_wrap = 0;
            end
            m_fw = m_wrap;
            if (m_full && (m_wrap || !en)) begin
                m_ftw  = s_ftw;
                m_wave = s_wave;
                m_amp  = s_amp;
                m_full = 0;
            end else if (cfg_valid && !m_full) begin
                s_ftw  = cfg_ftw;
                s_wave = cfg_wave;
                s_amp  = cfg_amp;
                m_full = 1;
            end
            exp_ready = !m_full;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("dac_data", dac_data, exp_dac);
            check("sync", sync, exp_sync);
            check("cfg_ready", cfg_ready, exp_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input logic [31:0] f, input logic [1:0] w,
                            input logic [7:0] a);
        bit done;
        done      = 1'b0;
        cfg_ftw   = f;
        cfg_wave  = w;
        cfg_amp   = a;
        cfg_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            done = cfg_ready;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("cfg_accepted", done, 1);
    endtask

    task automatic wait_sync(input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            if (sync) got = 1'b1;
            else @(negedge clk);
        end
        check("sync_seen", got, 1);
    endtask

    // Park with en low so the new config applies and acc restarts at 0.
    task automatic reconfig_idle(input logic [31:0] f, input logic [1:0] w,
                                 input logic [7:0] a);
        en = 1'b0;
        send_cfg(f, w, a);
        tick(1);
        en = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tick(2);
        check("rst_dac", dac_data, 8'h80);
        check("rst_sync", sync, 0);
        check("rst_ready", cfg_ready, 1);
        rst_n  = 1'b1;
        en     = 1'b1;
        chk_on = 1'b1;
        tick(40);

        // Pending shadow must be discarded by a mid-run reset.
        send_cfg(F24, 2'd2, 8'd255);
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dac", dac_data, 8'h80);
        check("midrst_sync", sync, 0);
        check("midrst_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(30);

        // Sawtooth
        reconfig_idle(F24, 2'd2, 8'd255);
        wait_sync(600);
        check("saw_p0", dac_data, 0);
        tick(1);
        check("saw_p1", dac_data, 1);
        tick(254);
        check("saw_p255", dac_data, 254);
        tick(1);
        check("saw_wrap_sync", sync, 1);
        check("saw_wrap_p0", dac_data, 0);

        // Sine
        reconfig_idle(F24, 2'd0, 8'd255);
        wait_sync(600);
        tick(63);
        check("sine_peak", dac_data, 254);
        tick(200);

        // Square, half and zero amplitude
        reconfig_idle(F24, 2'd3, 8'd128);
        wait_sync(600);
        tick(128);
        check("sq_amp128_low", dac_data, 64);
        reconfig_idle(F24, 2'd3, 8'd0);
        wait_sync(600);
        check("sq_amp0_hi", dac_data, 128);
        tick(128);
        check("sq_amp0_lo", dac_data, 128);

        // Mid-period sine -> triangle with a second offer held off
        reconfig_idle(F24, 2'd0, 8'd255);
        wait_sync(600);
        tick(100);
        send_cfg(F25, 2'd1, 8'd255);
        check("reconf_ready_low", cfg_ready, 0);
        cfg_ftw   = F24;
        cfg_wave  = 2'd3;
        cfg_amp   = 8'd128;
        cfg_valid = 1'b1;
        wait_sync(300);
        cfg_valid = 1'b0;
        check("tri_first", dac_data, 0);
        check("second_cfg_pending", cfg_ready, 0);
        tick(1);
        check("tri_second", dac_data, 4);

        // en toggle with a pending config
        wait_sync(300);
        tick(50);
        send_cfg(F23, 2'd2, 8'd200);
        en = 1'b0;
        tick(2);
        check("en_low_mid", dac_data, 128);
        check("en_low_applied", cfg_ready, 1);
        tick(8);
        en = 1'b1;
        tick(2);
        check("en_restart_p0", dac_data, 28);
        check("en_restart_nosync", sync, 0);
        tick(600);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
